// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared widths, types and default coefficients for the biquad filter
// Purpose : common definitions imported by iir_filter and iir_round_sat.
// Contents: SAMPLE_W/COEF_W/COEF_FRAC/ACC_W, sample_t/coef_t/acc_t,
//           default coefficient set (first-order unity-gain low-pass),
//           mul_ext helper returning a sign-extended 16x16 product.
package iir_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int COEF_W    = 16;
    localparam int COEF_FRAC = 14;
    localparam int ACC_W     = 36;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [COEF_W-1:0]   coef_t;
    typedef logic signed [ACC_W-1:0]    acc_t;

    // y[n] = 0.5*x[n] + 0.5*y[n-1]; A1 is subtracted, hence the negative value.
    localparam coef_t B0_DEFAULT = 16'sd8192;
    localparam coef_t B1_DEFAULT = 16'sd0;
    localparam coef_t B2_DEFAULT = 16'sd0;
    localparam coef_t A1_DEFAULT = -16'sd8192;
    localparam coef_t A2_DEFAULT = 16'sd0;

    // Full-precision 32-bit product, sign-extended into the accumulator width.
    function automatic acc_t mul_ext(input coef_t c, input sample_t s);
        logic signed [31:0] p;
        p = 32'(c) * 32'(s);
        return acc_t'(p);
    endfunction

endpackage

// File: rtl/iir_round_sat.sv
// rtl/iir_round_sat.sv - round-half-up, scale and saturate/wrap accumulator to a sample
// Purpose : converts the Q-format accumulator into an output sample.
// Ports   : i_acc    in  acc_t    raw accumulator (COEF_FRAC fractional bits)
//           o_sample out sample_t rounded result
// Config  : IIR_SATURATE_EN defined -> clamp to [-32768, 32767];
//           undefined -> keep low 16 bits (two's-complement wrap).
// Purely combinational.
module iir_round_sat
    import iir_pkg::*;
(
    input  acc_t    i_acc,
    output sample_t o_sample
);

    localparam acc_t ROUND_HALF = acc_t'(2 ** (COEF_FRAC - 1));

    acc_t w_rounded;
    acc_t w_shifted;

    // Adding half an LSB then flooring gives round-half-toward-+inf.
    assign w_rounded = i_acc + ROUND_HALF;
    assign w_shifted = w_rounded >>> COEF_FRAC;

`ifdef IIR_SATURATE_EN
    localparam acc_t SAT_MAX = acc_t'(32767);
    localparam acc_t SAT_MIN = acc_t'(-32768);

    always_comb begin
        o_sample = sample_t'(w_shifted);
        if (w_shifted > SAT_MAX) begin
            o_sample = 16'sh7fff;
        end else if (w_shifted < SAT_MIN) begin
            o_sample = 16'sh8000;
        end
    end
`else
    assign o_sample = sample_t'(w_shifted);
`endif

endmodule

// File: rtl/iir_filter.sv
// rtl/iir_filter.sv - direct-form-I biquad IIR filter, one sample per clock
// Purpose : y[n] = B0*x[n] + B1*x[n-1] + B2*x[n-2] - A1*y[n-1] - A2*y[n-2]
// Ports   : clk   in  1   rising-edge clock
//           reset in  1   synchronous active-high reset, clears all history
//           x     in  16  signed input sample, taken every non-reset edge
//           y     out 16  signed registered output (1-cycle latency)
// Params  : B0, B1, B2, A1, A2 signed Q2.14 coefficients
// Config  : IIR_SATURATE_EN selects clamping instead of wrap in iir_round_sat.
module iir_filter
    import iir_pkg::*;
#(
    parameter coef_t B0 = B0_DEFAULT,
    parameter coef_t B1 = B1_DEFAULT,
    parameter coef_t B2 = B2_DEFAULT,
    parameter coef_t A1 = A1_DEFAULT,
    parameter coef_t A2 = A2_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [SAMPLE_W-1:0] x,
    output logic signed [SAMPLE_W-1:0] y
);

    sample_t r_x1;
    sample_t r_x2;
    sample_t r_y2;

    acc_t    w_acc;
    sample_t w_result;

    // 36 bits holds five 32-bit products without overflow. The y register
    // itself serves as the y[n-1] history tap.
    assign w_acc = mul_ext(B0, x)
                 + mul_ext(B1, r_x1)
                 + mul_ext(B2, r_x2)
                 - mul_ext(A1, y)
                 - mul_ext(A2, r_y2);

    iir_round_sat u_round_sat (
        .i_acc    (w_acc),
        .o_sample (w_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            y    <= '0;
            r_y2 <= '0;
            r_x1 <= '0;
            r_x2 <= '0;
        end else begin
            y    <= w_result;
            r_y2 <= y;
            r_x2 <= r_x1;
            r_x1 <= x;
        end
    end

endmodule

// File: tb/tb_iir_filter.sv
// tb/tb_iir_filter.sv - scoreboard bench for iir_filter (default and integrator builds)
module tb_iir_filter;

    logic               clk;
    logic               reset;
    logic signed [15:0] x_a;
    logic signed [15:0] x_b;
    logic signed [15:0] y_a;
    logic signed [15:0] y_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [31:0] q_a[$];
    logic signed [31:0] q_b[$];

    // reference history for the default-coefficient instance
    longint mx1, mx2, my1, my2;

    iir_filter u_dut_a (
        .clk   (clk),
        .reset (reset),
        .x     (x_a),
        .y     (y_a)
    );

    iir_filter #(
        .B0 (16'sd16384),
        .A1 (-16'sd16384)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .x     (x_b),
        .y     (y_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint model_out(input longint xin);
        longint acc, r;
        acc = 64'sd8192 * xin - (-64'sd8192) * my1;
        r = (acc + 64'sd8192) >>> 14;
`ifdef IIR_SATURATE_EN
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`else
        r = longint'(16'(r) ^ 16'h8000) - 32768;
`endif
        return r;
    endfunction

    task automatic model_reset();
        mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        x_a   = 'x;
        x_b   = 'x;
        model_reset();
        @(posedge clk); #1;
        chk({tag, "_a"}, 32'(y_a), 32'sd0);
        chk({tag, "_b"}, 32'(y_b), 32'sd0);
        reset = 1'b0;
        x_a   = '0;
        x_b   = '0;
    endtask

    // drive one sample into DUT A; exp_v pushed to the scoreboard
    task automatic step_a(input string tag, input int xv, input int exp_v);
        longint yn;
        x_a = 16'(xv);
        x_b = '0;
        yn  = model_out(longint'(xv));
        mx2 = mx1; mx1 = longint'(xv); my2 = my1; my1 = yn;
        q_a.push_back(32'(exp_v));
        @(posedge clk); #1;
        if (q_a.size() == 0) chk({tag, "_empty"}, 32'sd1, 32'sd0);
        else chk(tag, 32'(y_a), q_a.pop_front());
    endtask

    task automatic step_a_model(input string tag, input int xv);
        step_a(tag, xv, int'(model_out(longint'(xv))));
    endtask

    task automatic step_b(input string tag, input int xv, input int exp_v);
        x_b = 16'(xv);
        x_a = '0;
        q_b.push_back(32'(exp_v));
        @(posedge clk); #1;
        if (q_b.size() == 0) chk({tag, "_empty"}, 32'sd1, 32'sd0);
        else chk(tag, 32'(y_b), q_b.pop_front());
    endtask

    initial begin
        reset = 1'b1;
        x_a   = 'x;
        x_b   = 'x;
        @(posedge clk);
        do_reset("reset");

        step_a("s0", 0, 0);
        step_a("s100", 100, 50);
        step_a("s150", 150, 100);
        step_a("s200", 200, 150);

        do_reset("midreset");
        step_a("after_reset", 100, 50);

        do_reset("r_step");
        step_a("step1", 100, 50);
        step_a("step2", 100, 75);
        step_a("step3", 100, 88);
        step_a("step4", 100, 94);
        step_a("step5", 100, 97);
        step_a("step6", 100, 99);
        step_a("step7", 100, 100);

        do_reset("r_neg3");
        step_a("neg3", -3, -1);
        do_reset("r_neg1");
        step_a("neg1", -1, 0);

        do_reset("r_full");
        step_a("full1", -32768, -16384);
        step_a("full2", -32768, -24576);
        for (int i = 0; i < 20; i++) step_a_model("full_n", -32768);
        chk("full_settled", 32'(y_a), -32'sd32767);

        do_reset("r_rand");
        for (int i = 0; i < 16; i++) step_a_model("rand", int'($urandom_range(0, 65535)) - 32768);

        do_reset("r_integ");
        step_b("integ1", 20000, 20000);
`ifdef IIR_SATURATE_EN
        step_b("integ2", 20000, 32767);
        step_b("integ3", 20000, 32767);
`else
        step_b("integ2", 20000, -25536);
        step_b("integ3", 20000, -5536);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
